// File: rtl/tx_frame_sequencer.sv
// Frame sequencer in front of a UART byte transmitter: arbitrates three response
// types, streams the chosen frame MSB byte first, then enforces a 3.5-char silence.
module tx_frame_sequencer #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tx_exp_rp_start,
    input  logic         tx_06_rp_start,
    input  logic         tx_03_04_rp_start,
    input  logic [39:0]  exception_seq,
    input  logic [63:0]  code06_response,
    input  logic [103:0] code03_04_response,
    input  logic         tx_done,
    output logic         tx_start,
    output logic [7:0]   tx_data,
    output logic         tx_busy,
    output logic         frame_done,
    output logic [1:0]   frame_type
);

    localparam int unsigned GAP_CYCLES = (CLK_FREQ / BAUD_RATE) * 39;
    localparam int unsigned GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSend, StWait, StGap} state_e;

    state_e             state_q;
    logic [2:0]         pend_q;
    logic [103:0]       shift_q;
    logic [3:0]         left_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               tx_start_q;
    logic [7:0]         tx_data_q;
    logic               tx_busy_q;
    logic               frame_done_q;
    logic [1:0]         frame_type_q;

    logic [2:0] req;
    logic [2:0] grant;

    // Bit 0 exception, bit 1 code06, bit 2 code03/04; lower index wins.
    assign req = {tx_03_04_rp_start, tx_06_rp_start, tx_exp_rp_start};

    always_comb begin
        grant = 3'b000;
        if (state_q == StIdle) begin
            if (pend_q[0]) begin
                grant = 3'b001;
            end else if (pend_q[1]) begin
                grant = 3'b010;
            end else if (pend_q[2]) begin
                grant = 3'b100;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pend_q       <= 3'b000;
            shift_q      <= '0;
            left_q       <= 4'd0;
            gap_cnt_q    <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_busy_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_type_q <= 2'd0;
        end else begin
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            // A request in the accept cycle re-arms the flag for a later frame.
            pend_q       <= (pend_q & ~grant) | req;

            case (state_q)
                StIdle: begin
                    if (grant != 3'b000) begin
                        state_q   <= StSend;
                        tx_busy_q <= 1'b1;
                        if (grant[0]) begin
                            shift_q      <= {exception_seq, 64'h0};
                            left_q       <= 4'd5;
                            frame_type_q <= 2'd1;
                        end else if (grant[1]) begin
                            shift_q      <= {code06_response, 40'h0};
                            left_q       <= 4'd8;
                            frame_type_q <= 2'd2;
                        end else begin
                            shift_q      <= code03_04_response;
                            left_q       <= 4'd13;
                            frame_type_q <= 2'd3;
                        end
                    end
                end
                StSend: begin
                    // Bytes after the first are already launched on the WAIT->SEND edge.
                    if (!tx_start_q) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= shift_q[103:96];
                        shift_q    <= {shift_q[95:0], 8'h00};
                        left_q     <= left_q - 4'd1;
                    end
                    state_q <= StWait;
                end
                StWait: begin
                    if (tx_done) begin
                        if (left_q != 4'd0) begin
                            state_q    <= StSend;
                            tx_start_q <= 1'b1;
                            tx_data_q  <= shift_q[103:96];
                            shift_q    <= {shift_q[95:0], 8'h00};
                            left_q     <= left_q - 4'd1;
                        end else begin
                            state_q      <= StGap;
                            frame_done_q <= 1'b1;
                            frame_type_q <= 2'd0;
                            gap_cnt_q    <= '0;
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q   <= StIdle;
                        tx_busy_q <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign tx_busy    = tx_busy_q;
    assign frame_done = frame_done_q;
    assign frame_type = frame_type_q;

endmodule
